// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-register pending-write scoreboard (optional forwarding: REGFILE_BYPASS_EN)
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [ADDR_W:0]          pend_cnt
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [DEPTH-1:0]  pend_nxt;
   logic [ADDR_W:0]   cnt_nxt;
   // next scoreboard: writebacks clear, a same-cycle issue then re-sets (new producer wins)
   always_comb begin
      pend_nxt = pending;
      for (int i = 0; i < NUM_WR; i++)
         if (wr_en[i]) pend_nxt[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
      if (iss_en) pend_nxt[iss_addr] = 1'b1;
      pend_nxt[0] = 1'b0;
      cnt_nxt = '0;
      for (int r = 0; r < DEPTH; r++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[r]);
   end
   // scoreboard and its population count register
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending  <= pend_nxt;
         pend_cnt <= cnt_nxt;
      end
   end
   // register array; later write ports override earlier ones on the same address
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else begin
         for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] != '0)
               regs[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
      end
   end
   // combinational read ports, zeroed while in reset, when disabled, or for x0
   always_comb begin : rd_blk
      logic [ADDR_W-1:0] ra;
      rd_data = '0;
      rd_busy = '0;
      ra = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         ra = rd_addr[j*ADDR_W +: ADDR_W];
         if (rst && rd_en[j] && ra != '0) begin
            rd_data[j*DATA_W +: DATA_W] = regs[ra];
            rd_busy[j] = pending[ra];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NUM_WR; i++)
               if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == ra) begin
                  rd_data[j*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
                  rd_busy[j] = iss_en && iss_addr == ra;
               end
`else
`endif
         end
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (default parameters)
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [5:0]  pend_cnt;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   regfile_mp dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_busy(rd_busy), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(string tag, int sel, logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic exp_port(string tag, int p, logic [31:0] d, logic b);
      push({tag, "_data"}, p, d);
      push({tag, "_busy"}, p + 2, {31'b0, b});
   endtask

   function automatic logic [31:0] observe(int sel);
      case (sel)
         0: return rd_data[31:0];
         1: return rd_data[63:32];
         2: return {31'b0, rd_busy[0]};
         3: return {31'b0, rd_busy[1]};
         default: return {26'b0, pend_cnt};
      endcase
   endfunction

   task automatic drain();
      exp_t e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic rd(logic [4:0] a0, logic [4:0] a1);
      rd_en = 2'b11;
      rd_addr = {a1, a0};
   endtask

   task automatic idle();
      wr_en = '0;
      wr_addr = '0;
      wr_data = '0;
      iss_en = 1'b0;
      iss_addr = '0;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      rd_en = '0;
      rd_addr = '0;
      step();
      step();
      rst = 1'b1;
      step();
      // after reset every register reads zero and idle
      for (int a = 0; a < 32; a++) begin
         rd(5'(a), 5'(a));
         exp_port($sformatf("rst_x%0d_p0", a), 0, 32'h0, 1'b0);
         exp_port($sformatf("rst_x%0d_p1", a), 1, 32'h0, 1'b0);
         drain();
      end
      push("rst_pend_cnt", 4, 32'd0);
      drain();
      // same-address write on both ports: port1 wins
      rd_en = '0;
      wr_en = 2'b11;
      wr_addr = {5'd5, 5'd5};
      wr_data = {32'h12345678, 32'hDEADBEEF};
      step();
      idle();
      rd(5'd5, 5'd5);
      exp_port("prio_p0", 0, 32'h12345678, 1'b0);
      exp_port("prio_p1", 1, 32'h12345678, 1'b0);
      drain();
      // disabled port reads zero even for a written register
      rd_en = 2'b10;
      exp_port("rden0_p0", 0, 32'h0, 1'b0);
      exp_port("rden0_p1", 1, 32'h12345678, 1'b0);
      drain();
      // x0 writes dropped
      rd_en = '0;
      wr_en = 2'b01;
      wr_addr = '0;
      wr_data = {32'h0, 32'hFFFFFFFF};
      step();
      idle();
      rd(5'd0, 5'd5);
      exp_port("x0_p0", 0, 32'h0, 1'b0);
      exp_port("x0_p1", 1, 32'h12345678, 1'b0);
      drain();
      // issue x7 marks it pending
      rd_en = '0;
      iss_en = 1'b1;
      iss_addr = 5'd7;
      step();
      idle();
      rd(5'd7, 5'd5);
      exp_port("iss7_p0", 0, 32'h0, 1'b1);
      exp_port("iss7_p1", 1, 32'h12345678, 1'b0);
      push("iss7_cnt", 4, 32'd1);
      drain();
      // writeback clears pending
      rd_en = '0;
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd7};
      wr_data = {32'h0, 32'hA5};
      step();
      idle();
      rd(5'd5, 5'd7);
      exp_port("wb7_p1", 1, 32'hA5, 1'b0);
      push("wb7_cnt", 4, 32'd0);
      drain();
      // issue and writeback to the same register: issue wins
      rd(5'd7, 5'd1);
      wr_en = 2'b10;
      wr_addr = {5'd7, 5'd0};
      wr_data = {32'hB6, 32'h0};
      iss_en = 1'b1;
      iss_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
      exp_port("isswb7_same", 0, 32'hB6, 1'b1);
`else
      exp_port("isswb7_same", 0, 32'hA5, 1'b0);
`endif
      drain();
      step();
      idle();
      exp_port("isswb7_p0", 0, 32'hB6, 1'b1);
      push("isswb7_cnt", 4, 32'd1);
      drain();
      // same-cycle write and read of x9
      rd(5'd9, 5'd9);
      rd_en = 2'b01;
      wr_en = 2'b10;
      wr_addr = {5'd9, 5'd0};
      wr_data = {32'h55, 32'h0};
`ifdef REGFILE_BYPASS_EN
      exp_port("byp9_same", 0, 32'h55, 1'b0);
`else
      exp_port("byp9_same", 0, 32'h0, 1'b0);
`endif
      exp_port("byp9_off", 1, 32'h0, 1'b0);
      drain();
      step();
      idle();
      exp_port("byp9_next", 0, 32'h55, 1'b0);
      drain();
      // issue x3, x4, x6 back to back
      rd_en = '0;
      iss_en = 1'b1;
      iss_addr = 5'd3;
      step();
      iss_addr = 5'd4;
      step();
      iss_addr = 5'd6;
      step();
      idle();
      rd(5'd3, 5'd6);
      exp_port("iss3_p0", 0, 32'h0, 1'b1);
      exp_port("iss6_p1", 1, 32'h0, 1'b1);
      push("iss346_cnt", 4, 32'd4);
      drain();
      // mid-operation reset with write and issue active
      rst = 1'b0;
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd10};
      wr_data = {32'h0, 32'h77};
      iss_en = 1'b1;
      iss_addr = 5'd12;
      rd(5'd5, 5'd3);
      exp_port("inrst_p0", 0, 32'h0, 1'b0);
      exp_port("inrst_p1", 1, 32'h0, 1'b0);
      drain();
      step();
      rst = 1'b1;
      idle();
      rd(5'd10, 5'd12);
      exp_port("postrst_x10", 0, 32'h0, 1'b0);
      exp_port("postrst_x12", 1, 32'h0, 1'b0);
      push("postrst_cnt", 4, 32'd0);
      drain();
      rd(5'd5, 5'd7);
      exp_port("postrst_x5", 0, 32'h0, 1'b0);
      exp_port("postrst_x7", 1, 32'h0, 1'b0);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
